// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue handshake bundle: fetch-side push, decode-side head and flush.
// The slave modport is the queue's view; master is the surrounding pipeline.
interface inst_fetch_queue_if #(
  parameter int BUS_WD = 109,
  parameter int PTR_WD = 3
);
  logic              fs_to_fq_valid;
  logic [BUS_WD-1:0] fs_to_fq_bus;
  logic              fq_allowin;
  logic              fq_to_ds_valid;
  logic [BUS_WD-1:0] fq_to_ds_bus;
  logic              ds_allowin;
  logic              flush;
  logic [PTR_WD:0]   fq_count;
  logic              fq_excp_lock;

  modport slave (
    input  fs_to_fq_valid, fs_to_fq_bus, ds_allowin, flush,
    output fq_allowin, fq_to_ds_valid, fq_to_ds_bus, fq_count, fq_excp_lock
  );

  modport master (
    output fs_to_fq_valid, fs_to_fq_bus, ds_allowin, flush,
    input  fq_allowin, fq_to_ds_valid, fq_to_ds_bus, fq_count, fq_excp_lock
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: circular buffer decoupling fetch from decode,
// emptied on flush and closed to new pushes once an excepting packet is held.
module inst_fetch_queue #(
  parameter int DEPTH  = 8,
  parameter int BUS_WD = 109,
  parameter int PTR_WD = 3
) (
  input  logic              clk,
  input  logic              reset,
  inst_fetch_queue_if.slave fq
);
  localparam logic [PTR_WD:0] FULL_CNT = (PTR_WD+1)'(DEPTH);
  localparam int              EXCP_BIT = 68;

  logic [BUS_WD-1:0] mem_q [DEPTH];
  logic [PTR_WD-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_WD-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WD:0]   count_q, count_d;
  logic              excp_lock_q, excp_lock_d;
  logic              push, pop;

  // Acceptance depends only on held state, so a full queue never pops through.
  assign fq.fq_allowin     = (count_q != FULL_CNT) && !excp_lock_q;
  assign fq.fq_to_ds_valid = (count_q != '0);
  assign fq.fq_to_ds_bus   = mem_q[rd_ptr_q];
  assign fq.fq_count       = count_q;
  assign fq.fq_excp_lock   = excp_lock_q;

  assign push = fq.fs_to_fq_valid && fq.fq_allowin && !fq.flush;
  assign pop  = fq.fq_to_ds_valid && fq.ds_allowin && !fq.flush;

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    excp_lock_d = excp_lock_q;
    if (fq.flush) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      excp_lock_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_WD'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_WD'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_WD+1)'(1);
        2'b01:   count_d = count_q - (PTR_WD+1)'(1);
        default: count_d = count_q;
      endcase
      if (push && fq.fs_to_fq_bus[EXCP_BIT]) excp_lock_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      excp_lock_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      excp_lock_q <= excp_lock_d;
    end
  end

  // Storage carries no reset; stale slots are masked by count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= fq.fs_to_fq_bus;
  end

  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    count_q <= FULL_CNT);

  a_head_stable: assert property (@(posedge clk) disable iff (reset)
    (fq.fq_to_ds_valid && !fq.ds_allowin && !fq.flush) |=> $stable(fq.fq_to_ds_bus));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomised and directed checks of inst_fetch_queue against a queue-based model.
module tb_inst_fetch_queue;
  localparam int BW = 109;
  localparam int DEPTH = 8;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  int   cyc;

  inst_fetch_queue_if #(.BUS_WD(BW), .PTR_WD(3)) fq_if ();

  inst_fetch_queue #(.DEPTH(DEPTH), .BUS_WD(BW), .PTR_WD(3)) dut (
    .clk   (clk),
    .reset (reset),
    .fq    (fq_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an ordered list of held packets plus the lock bit.
  logic [BW-1:0] mq[$];
  bit            mlock;

  task automatic check_eq(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] mkpkt(input logic [31:0] pc, input logic excp);
    logic [127:0] r;
    logic [BW-1:0] p;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    p = r[BW-1:0];
    p[31:0] = pc;
    p[68] = excp;
    return p;
  endfunction

  task automatic check_outputs();
    check_eq("count", BW'(fq_if.fq_count), BW'(mq.size()));
    check_eq("valid", BW'(fq_if.fq_to_ds_valid), BW'(mq.size() != 0));
    check_eq("allowin", BW'(fq_if.fq_allowin), BW'((mq.size() != DEPTH) && !mlock));
    check_eq("lock", BW'(fq_if.fq_excp_lock), BW'(mlock));
    if (mq.size() != 0) check_eq("head", fq_if.fq_to_ds_bus, mq[0]);
  endtask

  // One clock: drive, check at the falling edge, advance the model at the rising edge.
  task automatic cycle(input logic v, input logic [BW-1:0] b, input logic da, input logic fl);
    bit allow, push, pop;
    fq_if.fs_to_fq_valid = v;
    fq_if.fs_to_fq_bus   = b;
    fq_if.ds_allowin     = da;
    fq_if.flush          = fl;
    @(negedge clk);
    check_outputs();
    allow = (mq.size() != DEPTH) && !mlock;
    push  = v && allow && !fl;
    pop   = (mq.size() != 0) && da && !fl;
    $display("cyc %0d v=%0b da=%0b flush=%0b push=%0b pop=%0b pc=%h count=%0d",
             cyc, v, da, fl, push, pop, b[31:0], mq.size());
    if (fl) begin
      mq.delete();
      mlock = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(b);
        if (b[68]) mlock = 1'b1;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic da);
    cycle(1'b0, '0, da, 1'b0);
  endtask

  task automatic do_flush();
    cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [31:0] pc;
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    mlock = 1'b0;
    reset = 1'b1;
    fq_if.fs_to_fq_valid = 1'b0;
    fq_if.fs_to_fq_bus   = '0;
    fq_if.ds_allowin     = 1'b0;
    fq_if.flush          = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check_eq("rst_valid", BW'(fq_if.fq_to_ds_valid), BW'(0));
    check_eq("rst_allowin", BW'(fq_if.fq_allowin), BW'(1));
    check_eq("rst_count", BW'(fq_if.fq_count), BW'(0));

    // Streaming through a single entry.
    for (int i = 0; i < 8; i++) cycle(1'b1, mkpkt(32'h1c000000 + 32'(4*i), 1'b0), 1'b1, 1'b0);
    check_eq("stream_count", BW'(fq_if.fq_count), BW'(1));
    check_eq("stream_head_pc", BW'(fq_if.fq_to_ds_bus[31:0]), BW'(32'h1c00001c));
    idle(1'b1);

    // Fill then drain.
    for (int i = 0; i < 8; i++) cycle(1'b1, mkpkt(32'h1c000000 + 32'(4*i), 1'b0), 1'b0, 1'b0);
    check_eq("fill_count", BW'(fq_if.fq_count), BW'(8));
    check_eq("fill_allowin", BW'(fq_if.fq_allowin), BW'(0));
    check_eq("fill_head_pc", BW'(fq_if.fq_to_ds_bus[31:0]), BW'(32'h1c000000));
    for (int i = 0; i < 8; i++) idle(1'b1);
    check_eq("drain_valid", BW'(fq_if.fq_to_ds_valid), BW'(0));

    // Full with a simultaneous offer and pop: offer refused, then taken.
    for (int i = 0; i < 8; i++) cycle(1'b1, mkpkt(32'h1c000040 + 32'(4*i), 1'b0), 1'b0, 1'b0);
    cycle(1'b1, mkpkt(32'h1c000060, 1'b0), 1'b1, 1'b0);
    check_eq("full_pop_count", BW'(fq_if.fq_count), BW'(7));
    cycle(1'b1, mkpkt(32'h1c000060, 1'b0), 1'b0, 1'b0);
    check_eq("full_refill_count", BW'(fq_if.fq_count), BW'(8));
    for (int i = 0; i < 8; i++) idle(1'b1);

    // Exception lock.
    cycle(1'b1, mkpkt(32'h1c000000, 1'b0), 1'b0, 1'b0);
    cycle(1'b1, mkpkt(32'h1c000004, 1'b0), 1'b0, 1'b0);
    begin
      logic [BW-1:0] ep;
      ep = mkpkt(32'h1c000008, 1'b1);
      ep[67:64] = 4'b0010;
      cycle(1'b1, ep, 1'b0, 1'b0);
    end
    check_eq("lock_set", BW'(fq_if.fq_excp_lock), BW'(1));
    check_eq("lock_allowin", BW'(fq_if.fq_allowin), BW'(0));
    for (int i = 0; i < 5; i++) cycle(1'b1, mkpkt(32'h1c00000c + 32'(4*i), 1'b0), 1'b1, 1'b0);
    check_eq("lock_drained", BW'(fq_if.fq_to_ds_valid), BW'(0));
    cycle(1'b1, mkpkt(32'h1c000020, 1'b0), 1'b0, 1'b1);
    check_eq("lock_cleared", BW'(fq_if.fq_allowin), BW'(1));

    // Flush with push and pop offered in the same cycle.
    for (int i = 0; i < 5; i++) cycle(1'b1, mkpkt(32'h1c000080 + 32'(4*i), 1'b0), 1'b0, 1'b0);
    cycle(1'b1, mkpkt(32'h1c0000f0, 1'b0), 1'b1, 1'b1);
    check_eq("flush_count", BW'(fq_if.fq_count), BW'(0));
    check_eq("flush_valid", BW'(fq_if.fq_to_ds_valid), BW'(0));
    cycle(1'b1, mkpkt(32'h1c000100, 1'b0), 1'b0, 1'b0);
    check_eq("flush_new_head", BW'(fq_if.fq_to_ds_bus[31:0]), BW'(32'h1c000100));
    do_flush();

    // Randomised traffic.
    pc = 32'h1c001000;
    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 3) != 0, mkpkt(pc, $urandom_range(0, 15) == 0),
            $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
      pc += 32'd4;
    end
    do_flush();

    // Asynchronous reset in the middle of a cycle with three entries held.
    for (int i = 0; i < 3; i++) cycle(1'b1, mkpkt(32'h1c000200 + 32'(4*i), 1'b0), 1'b0, 1'b0);
    fq_if.fs_to_fq_valid = 1'b0;
    fq_if.ds_allowin     = 1'b0;
    #3 reset = 1'b1;
    #1;
    check_eq("areset_valid", BW'(fq_if.fq_to_ds_valid), BW'(0));
    check_eq("areset_count", BW'(fq_if.fq_count), BW'(0));
    mq.delete();
    mlock = 1'b0;
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b1, mkpkt(32'h1c000300, 1'b0), 1'b0, 1'b0);
    check_eq("post_reset_head", BW'(fq_if.fq_to_ds_bus[31:0]), BW'(32'h1c000300));
    idle(1'b1);
    idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Decoupling FIFO between the fetch stage and the decode stage.
- Accepts 109-bit fetch packets `{btb_ret_pc[108:77], btb_index[76:72], btb_taken[71], btb_en[70], icache_miss[69], excp[68], excp_num[67:64], inst[63:32], pc[31:0]}` under the valid/allowin handshake.
- Presents the oldest packet to decode.
- Absorbs decode stalls so fetch keeps streaming, and is emptied on any pipeline flush.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- BUS_WD, 109, packet width in bits.
- PTR_WD, 3, log2(DEPTH).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- fs_to_fq_valid  input  1  upstream packet valid
- fs_to_fq_bus  input  BUS_WD  upstream packet
- fq_allowin  output  1  queue can accept a packet this cycle
- fq_to_ds_valid  output  1  head packet valid
- fq_to_ds_bus  output  BUS_WD  head packet
- ds_allowin  input  1  decode accepts head this cycle
- flush  input  1  OR of excp/ertn/refetch/icacop/idle flushes and the branch-mispredict flush
- fq_count  output  PTR_WD+1  number of valid entries
- fq_excp_lock  output  1  an exception packet is held; further pushes are blocked

Behaviour:
- Reset (async, active-high):
  - rd_ptr=0, wr_ptr=0, count=0, excp_lock=0.
  - Outputs: fq_to_ds_valid=0, fq_allowin=1, fq_count=0, fq_excp_lock=0.
  - Entry storage is not reset. fq_to_ds_bus is don't-care while fq_to_ds_valid=0.
- Handshake:
  - push = fs_to_fq_valid && fq_allowin && !flush.
  - pop = fq_to_ds_valid && ds_allowin && !flush.
- fq_allowin = (count != DEPTH) && !excp_lock.
  - Purely state-based; does not look at ds_allowin or flush. No pop-through when full.
- fq_to_ds_valid = (count != 0). fq_to_ds_bus = mem[rd_ptr], read combinationally from the registered array.
- Latency: a packet pushed in cycle N is visible at the head in cycle N+1 at the earliest. There is no same-cycle bypass.
- Push: mem[wr_ptr] <= fs_to_fq_bus; wr_ptr <= wr_ptr+1.
- Pop: rd_ptr <= rd_ptr+1.
- Pointers are PTR_WD bits and wrap modulo DEPTH.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle: unchanged, and both pointers advance.
- Exception lock:
  - On a push with fs_to_fq_bus[68]=1, excp_lock <= 1.
  - While locked, fq_allowin=0. Packets already queued keep draining normally.
  - The lock clears only on flush or reset. The excepting instruction traps at writeback and always raises a flush.
- Flush (synchronous, highest priority):
  - Next cycle: rd_ptr=wr_ptr=0, count=0, excp_lock=0.
  - Any push or pop offered in the flush cycle is discarded.
  - During the flush cycle the outputs still reflect pre-flush state. Decode must itself ignore a handshake in a flush cycle.
- Boundary cases:
  - Full with pop: allowin stays 0 that cycle; count becomes DEPTH-1.
  - Empty with push: valid rises in the next cycle.
  - Push in the cycle reset is released: honoured normally.
  - Reset mid-stream: everything is lost immediately (asynchronous).
- Assertions for verification:
  - count never exceeds DEPTH.
  - No push while !fq_allowin.
  - Head packet is stable while fq_to_ds_valid && !ds_allowin && !flush.

Test Plan:
- Streaming: ds_allowin=1, push pc 0x1c000000..0x1c00001c one per cycle -> head pc sequence is identical, each one cycle after its push; count stays 1; fq_allowin stays 1.
- Fill/drain: ds_allowin=0, push 8 packets -> count=8, fq_allowin=0, head pc=0x1c000000. Then ds_allowin=1 with no pushes -> 8 pops in order, count=0, fq_to_ds_valid=0.
- Full with simultaneous offer: count=8, fs_to_fq_valid=1, ds_allowin=1 -> offered packet is not accepted; count=7; the packet is accepted in the next cycle -> count returns to 8; wrap-around order is preserved.
- Exception lock: push pc 0x1c000008 with bit68=1 and excp_num=4'b0010, keep fs_to_fq_valid=1 -> fq_excp_lock=1, fq_allowin=0. The queue drains through that packet, then valid=0. flush=1 -> lock clears and fq_allowin=1 next cycle.
- Flush with traffic: count=5, flush=1 together with push and pop -> next cycle count=0, valid=0, no entry written. Push pc 0x1c000100 -> it appears as the head.
- Async reset: assert reset mid-cycle with count=3 -> fq_to_ds_valid=0 and fq_count=0 before the next clock edge.
